// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, drives a combinational instruction-memory word address, and
// latches the fetched word into IF/ID. A HALT word (opcode 6'b111111) parks
// the stage in HALTED until a taken branch redirects it.
//
// Optional build macro: FETCH_PERF_CNT_EN adds the saturating stallCount and
// flushCount performance counters. Without it, neither port nor logic exists.
//
// state  | meaning
// -------+---------------------------------------------------------------
// RUN    | fetching sequentially, loading IF/ID every non-stalled cycle
// HALTED | HALT word has entered IF/ID; PC frozen, IF/ID fed bubbles

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               stall,
    input  logic               flush,
    input  logic               branchTakenFlag,
    input  logic [31:0]        branchTarget,
    output logic [31:0]        instr_D,
    output logic [31:0]        pc_D,
    output logic [31:0]        pcPlus4_D,
    output logic               valid_D,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stallCount,
    output logic [31:0]        flushCount
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic        fetch_is_halt;
    logic        loads_halt;

    assign pc_plus4      = pc + 32'd4;
    assign redirect_pc   = branchTarget & 32'hFFFF_FFFC;
    assign imem_addr     = pc[IMEM_AW+1:2];
    assign fetch_is_halt = (imem_rdata[31:26] == 6'b111111);
    // A HALT word only counts once it actually lands in IF/ID as valid.
    assign loads_halt    = (state == RUN) && !flush && !stall && fetch_is_halt;

    // Program counter: reset, then redirect, then hold, then sequential.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (branchTakenFlag) begin
            pc <= redirect_pc;
        end else if (!stall && (state != HALTED)) begin
            pc <= pc_plus4;
        end
    end

    // IF/ID register: flush beats stall, stall beats the halted bubble.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr_D   <= 32'h0;
            pc_D      <= 32'h0;
            pcPlus4_D <= 32'h0;
            valid_D   <= 1'b0;
        end else if (stall) begin
            instr_D   <= instr_D;
        end else if (state == HALTED) begin
            instr_D   <= 32'h0;
            pc_D      <= 32'h0;
            pcPlus4_D <= 32'h0;
            valid_D   <= 1'b0;
        end else begin
            instr_D   <= imem_rdata;
            pc_D      <= pc;
            pcPlus4_D <= pc_plus4;
            valid_D   <= 1'b1;
        end
    end

    // Halt FSM with registered halted flag; a taken branch always resumes RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            halted <= 1'b0;
        end else if (branchTakenFlag) begin
            state  <= RUN;
            halted <= 1'b0;
        end else if (loads_halt) begin
            state  <= HALTED;
            halted <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counts of stalled and flushed edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount <= 32'h0;
            flushCount <= 32'h0;
        end else begin
            if (stall && (stallCount != 32'hFFFF_FFFF)) begin
                stallCount <= stallCount + 32'd1;
            end
            if (flush && (flushCount != 32'hFFFF_FFFF)) begin
                flushCount <= flushCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage core. Holds the PC, drives the instruction-memory read address, and latches the fetched word into IF/ID for decode. Consumes the hazard unit's stall, decode-stage flush and branch-taken outputs, and stops fetching on a HALT instruction.

## Interface
- RESET_PC, default 32'h0000_0000: PC value loaded on reset; must be word aligned.
- IMEM_AW, default 10: instruction-memory word-address width.

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_addr  out  IMEM_AW  word address; combinational, equal to pc[IMEM_AW+1:2]
- imem_rdata  in  32  instruction word; asynchronous read, valid in the same cycle as imem_addr
- stall  in  1  hazard-unit stall; freezes the PC and IF/ID
- flush  in  1  hazard-unit flush for IF/ID; loads a bubble
- branchTakenFlag  in  1  taken branch resolved downstream; redirects the PC
- branchTarget  in  32  redirect address; bits [1:0] are ignored and forced to 0
- instr_D  out  32  IF/ID instruction
- pc_D  out  32  IF/ID instruction address
- pcPlus4_D  out  32  IF/ID pc+4
- valid_D  out  1  IF/ID holds a real instruction
- halted  out  1  FSM is in HALTED
- stallCount  out  32  saturating stall-cycle counter; present only with the macro set
- flushCount  out  32  saturating flush counter; present only with the macro set

## Operation
- HALT encoding: instr[31:26] == 6'b111111.
- FSM states: RUN and HALTED. Reset state is RUN.
- RUN to HALTED: the edge that loads a HALT word into IF/ID with valid_D=1.
- HALTED to RUN: only on branchTakenFlag, or on rst.
- Next PC, in priority order:
  - rst: RESET_PC
  - branchTakenFlag: {branchTarget[31:2],2'b00}
  - stall, or state HALTED: hold
  - otherwise: pc+4
- Next IF/ID, in priority order:
  - rst or flush: bubble (instr_D=0, pc_D=0, pcPlus4_D=0, valid_D=0)
  - stall: hold
  - HALTED: bubble
  - otherwise: load {imem_rdata, pc, pc+4}, with valid_D=1
- branchTakenFlag alone does not clear IF/ID. The hazard unit must assert flush in the same cycle.
- branchTakenFlag together with stall: the PC still redirects. IF/ID follows the flush/stall priority above.
- A taken branch while HALTED cancels the halt. A HALT word already in IF/ID is removed only by flush.
- PC arithmetic is 32-bit modulo 2^32 (0xFFFF_FFFC + 4 = 0). imem_addr ignores the PC bits above IMEM_AW+1.

## Timing
- Reset values: pc=RESET_PC, instr_D=0, pc_D=0, pcPlus4_D=0, valid_D=0, halted=0, counters=0.
- Fetch latency is 1 cycle. The word at address pc appears on instr_D after the next rising edge.
- Redirect: branchTakenFlag high in cycle t gives pc=target after edge t, and instr_D=mem[target] after edge t+1.
- Stall: while stall is high, pc and all IF/ID outputs are stable. Fetch resumes the cycle after stall drops, with no lost instruction.
- Halt: the HALT word sits in IF/ID for exactly one non-stalled cycle. halted goes to 1 on that same edge and IF/ID shows bubbles after it.
- Reset mid-operation: all registers and the FSM take reset values at that edge, whatever the other inputs are.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - stallCount increments on every edge with stall=1 and rst=0.
  - flushCount increments on every edge with flush=1 and rst=0.
  - Both counters saturate at 32'hFFFF_FFFF.
- FETCH_PERF_CNT_EN undefined: stallCount and flushCount are not declared and no counter logic is built.

## Test plan
- Sequential fetch: reset with RESET_PC=0 and mem[i]=i+100. After 3 edges with no hazards: pc=12, instr_D=102, pc_D=8, pcPlus4_D=12, valid_D=1.
- Stall: stall=1 for 2 cycles while instr_D=101, pc=8. pc stays 8 and instr_D stays 101. After release, instr_D=102.
- Branch: at pc=16, pulse branchTakenFlag=1, flush=1 with branchTarget=0x43. Next edge: pc=0x40, valid_D=0. Following edge: pc_D=0x40, instr_D=mem[16].
- Halt: mem[3]=32'hFC00_0000. After the edge loading it: halted=1 and pc stays 16. The next edge gives valid_D=0. A branchTakenFlag to 0 then clears halted and gives pc=0.
- Simultaneous: stall=1, flush=1 and branchTakenFlag=1 to target 0x20 in one cycle. Result: valid_D=0 and pc=0x20. With FETCH_PERF_CNT_EN, stallCount=1 and flushCount=1.
- Wrap and reset: RESET_PC=32'hFFFF_FFFC. After one edge, pc=0. Asserting rst mid-run returns every output to its reset value on the next edge.
